alu_exec_unit: RTL and testbench

- Integer execution unit directly downstream of the reservation station.
- Accepts one ready operation per cycle as {op[3:0], rob[5:0], valA[15:0], valB[15:0]}.
- Computes a 16-bit result: single-cycle ops plus a 3-stage pipelined multiplier.
- Drives one forwarding bus {valid, rob[5:0], value[15:0]}. That bus feeds the reservation stations' forward inputs and the ROB.

---
 rtl/exec_pkg.sv | 47 ++++
 rtl/mul_pipe.sv | 51 +++++
 rtl/alu_exec_unit.sv | 143 ++++++++++++++
 tb/tb_alu_exec_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared definitions for the integer execution unit: widths, op encodings,
// issue-packet and forwarding-bus field offsets, and the queued result record.
package exec_pkg;

    localparam int DATA_W  = 16;
    localparam int ROB_W   = 6;
    localparam int MUL_LAT = 3;
    localparam int QDEPTH  = 4;

    // Issue packet layout {op, rob, valA, valB}
    localparam int OPER_W  = 42;
    localparam int OP_HI   = 41;
    localparam int OP_LO   = 38;
    localparam int ROB_HI  = 37;
    localparam int ROB_LO  = 32;
    localparam int VALA_HI = 31;
    localparam int VALA_LO = 16;
    localparam int VALB_HI = 15;
    localparam int VALB_LO = 0;

    // Forwarding bus layout {valid, rob, value}
    localparam int FWD_W      = 23;
    localparam int FWD_VALID  = 22;
    localparam int FWD_ROB_HI = 21;
    localparam int FWD_ROB_LO = 16;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_MUL  = 4'd10,
        ALU_MULH = 4'd11
    } alu_op_e;

    typedef struct packed {
        logic [ROB_W-1:0]  rob;
        logic [DATA_W-1:0] value;
    } result_t;

endpackage

// File: rtl/mul_pipe.sv
// Pipelined 16x16 unsigned multiplier. Two register stages live here
// (operands, then full product); the hi/lo select is combinational so the
// owner's forwarding register acts as the third stage.
module mul_pipe
    import exec_pkg::*;
(
    input  logic              clk,
    input  logic              clear,
    input  logic              in_valid,
    input  logic              in_hi,
    input  logic [ROB_W-1:0]  in_rob,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    output logic [ROB_W-1:0]  out_rob,
    output logic [DATA_W-1:0] out_value
);

    logic                v1, v2;
    logic                hi1, hi2;
    logic [ROB_W-1:0]    rob1, rob2;
    logic [DATA_W-1:0]   a1, b1;
    logic [2*DATA_W-1:0] prod2;

    // Stage valids, cleared synchronously by reset or flush
    always_ff @(posedge clk) begin
        if (clear) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            v1 <= in_valid;
            v2 <= v1;
        end
    end

    // Data and sideband path; contents are meaningless while the valid is low
    always_ff @(posedge clk) begin
        hi1   <= in_hi;
        rob1  <= in_rob;
        a1    <= in_a;
        b1    <= in_b;
        hi2   <= hi1;
        rob2  <= rob1;
        prod2 <= (2*DATA_W)'(a1) * (2*DATA_W)'(b1);
    end

    assign out_valid = v2;
    assign out_rob   = rob2;
    assign out_value = hi2 ? prod2[2*DATA_W-1:DATA_W] : prod2[DATA_W-1:0];

endmodule

// File: rtl/alu_exec_unit.sv
// Integer execution unit: single-cycle ALU, pipelined multiplier, and a small
// skid FIFO that serialises completions onto one registered forwarding bus.
module alu_exec_unit
    import exec_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              inValid,
    input  logic [OPER_W-1:0] inOperation,
    output logic [FWD_W-1:0]  forwardOut,
    output logic              queueOverflow
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = $clog2(QDEPTH + 1);

    logic [3:0]        op;
    logic [ROB_W-1:0]  rob;
    logic [DATA_W-1:0] val_a, val_b;
    logic [3:0]        shamt;
    logic              issue, is_mul;
    logic [DATA_W-1:0] alu_value;
    logic              short_valid;
    result_t           short_res;

    logic              mul_valid;
    logic [ROB_W-1:0]  mul_rob;
    logic [DATA_W-1:0] mul_value;

    result_t           mem [QDEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count;
    result_t           head;

    logic              out_valid, pop, push, wr_en, ovf_set;
    result_t           out_res;
    logic [FWD_W-1:0]  fwd_q;
    logic              ovf_q;

    assign op     = inOperation[OP_HI:OP_LO];
    assign rob    = inOperation[ROB_HI:ROB_LO];
    assign val_a  = inOperation[VALA_HI:VALA_LO];
    assign val_b  = inOperation[VALB_HI:VALB_LO];
    assign shamt  = val_b[3:0];
    assign issue  = inValid && rst_n && !flush;
    assign is_mul = (op == ALU_MUL) || (op == ALU_MULH);

    // Single-cycle ALU; undefined op codes yield zero
    always_comb begin
        alu_value = '0;
        case (op)
            ALU_ADD:  alu_value = val_a + val_b;
            ALU_SUB:  alu_value = val_a - val_b;
            ALU_AND:  alu_value = val_a & val_b;
            ALU_OR:   alu_value = val_a | val_b;
            ALU_XOR:  alu_value = val_a ^ val_b;
            ALU_SLL:  alu_value = val_a << shamt;
            ALU_SRL:  alu_value = val_a >> shamt;
            ALU_SRA:  alu_value = $signed(val_a) >>> shamt;
            ALU_SLT:  alu_value = {{(DATA_W-1){1'b0}}, ($signed(val_a) < $signed(val_b))};
            ALU_SLTU: alu_value = {{(DATA_W-1){1'b0}}, (val_a < val_b)};
            default:  alu_value = '0;
        endcase
    end

    assign short_valid     = issue && !is_mul;
    assign short_res.rob   = rob;
    assign short_res.value = alu_value;

    mul_pipe u_mul (
        .clk       (clk),
        .clear     (!rst_n || flush),
        .in_valid  (issue && is_mul),
        .in_hi     (op == ALU_MULH),
        .in_rob    (rob),
        .in_a      (val_a),
        .in_b      (val_b),
        .out_valid (mul_valid),
        .out_rob   (mul_rob),
        .out_value (mul_value)
    );

    assign head = mem[rd_ptr];

    // Output arbitration. With a 3-cycle multiplier, anything still queued when
    // a MUL completes was issued after it, so a completing MUL is always the
    // oldest candidate and a fresh short op is always the youngest; fixed
    // priority MUL > queue head > short op therefore preserves issue order.
    always_comb begin
        out_valid = 1'b0;
        out_res   = '0;
        pop       = 1'b0;
        push      = 1'b0;
        if (mul_valid) begin
            out_valid     = 1'b1;
            out_res.rob   = mul_rob;
            out_res.value = mul_value;
            push          = short_valid;
        end else if (count != '0) begin
            out_valid = 1'b1;
            out_res   = head;
            pop       = 1'b1;
            push      = short_valid;
        end else if (short_valid) begin
            out_valid = 1'b1;
            out_res   = short_res;
        end
        wr_en   = push && ((count != CNT_W'(QDEPTH)) || pop);
        ovf_set = push && !wr_en;
    end

    // Queue storage; stale entries are harmless because count gates reads
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= short_res;
    end

    // Queue pointers, forwarding register and sticky overflow flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            fwd_q  <= '0;
            ovf_q  <= 1'b0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            fwd_q  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(wr_en) - CNT_W'(pop);
            fwd_q <= out_valid ? {1'b1, out_res.rob, out_res.value} : '0;
            if (ovf_set) ovf_q <= 1'b1;
        end
    end

    assign forwardOut    = fwd_q;
    assign queueOverflow = ovf_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios followed by random
// traffic, all compared each cycle against an issue-ordered reference model.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        inValid;
    logic [41:0] inOperation;
    logic [22:0] forwardOut;
    logic        queueOverflow;

    alu_exec_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .inValid       (inValid),
        .inOperation   (inOperation),
        .forwardOut    (forwardOut),
        .queueOverflow (queueOverflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  rob;
        logic [15:0] val;
        int          ready;
    } pend_t;

    pend_t       pend[$];
    logic [5:0]  seen[$];
    int          edge_n = 0;
    int          passed = 0;
    int          total  = 0;
    logic [22:0] exp_fwd = '0;
    logic        exp_ovf = 1'b0;

    function automatic logic [15:0] ref_alu(input int op, input int a, input int b);
        int     sa, sb, sh;
        longint p;
        sa = (a >= 32768) ? a - 65536 : a;
        sb = (b >= 32768) ? b - 65536 : b;
        sh = b % 16;
        p  = longint'(a) * longint'(b);
        case (op)
            0:  return 16'(a + b);
            1:  return 16'(a - b);
            2:  return 16'(a & b);
            3:  return 16'(a | b);
            4:  return 16'(a ^ b);
            5:  return 16'(a << sh);
            6:  return 16'(a >> sh);
            7:  return 16'(sa >>> sh);
            8:  return (sa < sb) ? 16'd1 : 16'd0;
            9:  return (a < b) ? 16'd1 : 16'd0;
            10: return 16'(p);
            11: return 16'(p >> 16);
            default: return 16'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [22:0] obs, input logic [22:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    // One clock: drive inputs, advance the model for this edge, compare after it
    task automatic cyc(input bit v, input int op, input int rob, input int a, input int b,
                       input bit fl, input bit rs, input string tag);
        int    idx;
        pend_t e;
        inValid     = v;
        inOperation = {4'(op), 6'(rob), 16'(a), 16'(b)};
        flush       = fl;
        rst_n       = !rs;
        @(posedge clk);
        edge_n++;
        exp_fwd = '0;
        if (rs) begin
            pend.delete();
            exp_ovf = 1'b0;
        end else if (fl) begin
            pend.delete();
        end else begin
            if (v) begin
                e.rob   = 6'(rob);
                e.val   = ref_alu(op, a & 16'hFFFF, b & 16'hFFFF);
                e.ready = edge_n + ((op == 10 || op == 11) ? 2 : 0);
                pend.push_back(e);
            end
            idx = -1;
            for (int i = 0; i < pend.size(); i++) begin
                if (idx < 0 && pend[i].ready <= edge_n) idx = i;
            end
            if (idx >= 0) begin
                exp_fwd = {1'b1, pend[idx].rob, pend[idx].val};
                pend.delete(idx);
            end
        end
        #1;
        if (forwardOut[22] === 1'b1) seen.push_back(forwardOut[21:16]);
        chk({tag, "_fwd"}, forwardOut, exp_fwd);
        chk({tag, "_ovf"}, {22'd0, queueOverflow}, {22'd0, exp_ovf});
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    initial begin
        int cnt;
        int op;
        rst_n = 1'b0; flush = 1'b0; inValid = 1'b0; inOperation = '0;

        // Reset, with an issue that must be ignored
        cyc(1, 0, 3, 1, 1, 0, 1, "reset0");
        cyc(0, 0, 0, 0, 0, 0, 1, "reset1");
        chk("reset_fwd_zero", forwardOut, 23'h0);
        idle(1, "post_reset");

        // Short ops: ADD overflow wrap and SUB underflow, one-cycle latency
        cyc(1, 0, 5, 16'h7FFF, 16'h0001, 0, 0, "add");
        chk("add_value", forwardOut, 23'h458000);
        cyc(1, 1, 6, 16'h0000, 16'h0001, 0, 0, "sub");
        chk("sub_value", forwardOut, 23'h46FFFF);
        idle(1, "gap0");

        // MUL / MULH with three-cycle latency
        cyc(1, 10, 9, 16'h1234, 16'h0100, 0, 0, "mul");
        idle(1, "mul_wait");
        chk("mul_not_early", {22'd0, forwardOut[22]}, 23'h0);
        idle(1, "mul_done");
        chk("mul_value", forwardOut, 23'h493400);
        cyc(1, 11, 10, 16'h1234, 16'h0100, 0, 0, "mulh");
        idle(2, "mulh_wait");
        chk("mulh_value", forwardOut, 23'h4A0012);
        idle(1, "gap1");

        // Completion collision: MUL at t, ADD at t+2
        cyc(1, 10, 1, 3, 4, 0, 0, "col_mul");
        idle(1, "col_gap");
        cyc(1, 0, 2, 2, 3, 0, 0, "col_add");
        chk("col_mul_first", forwardOut, 23'h41000C);
        idle(1, "col_tail");
        chk("col_add_next", forwardOut, 23'h420005);
        idle(2, "gap2");

        // Alternating MUL/ADD stream, tags 20..39
        seen.delete();
        for (int i = 0; i < 20; i++)
            cyc(1, (i % 2 == 0) ? 10 : 0, 20 + i, $urandom_range(0, 65535),
                $urandom_range(0, 65535), 0, 0, "stream");
        idle(4, "stream_drain");
        chk("stream_count", 23'(seen.size()), 23'd20);
        for (int t = 20; t < 40; t++) begin
            cnt = 0;
            foreach (seen[k]) if (seen[k] == 6'(t)) cnt++;
            chk("stream_once", 23'(cnt), 23'd1);
        end
        chk("stream_no_ovf", {22'd0, queueOverflow}, 23'h0);

        // Flush with MUL and SRA in flight, then a fresh ADD
        cyc(1, 10, 40, 16'h0003, 16'h0005, 0, 0, "fl_mul");
        cyc(1, 7, 41, 16'h8000, 16'h0004, 1, 0, "fl_sra");
        chk("flush_no_valid", {22'd0, forwardOut[22]}, 23'h0);
        cyc(1, 0, 42, 16'h0010, 16'h0020, 0, 0, "fl_add");
        chk("flush_add_out", forwardOut, 23'h6A0030);
        idle(3, "fl_quiet");
        cyc(1, 7, 43, 16'h8000, 16'h0004, 0, 0, "sra");
        chk("sra_value", forwardOut, 23'h6BF800);
        idle(1, "gap3");

        // Reset mid-stream, then signed / unsigned compare
        cyc(1, 10, 44, 7, 7, 0, 0, "rs_mul");
        cyc(1, 0, 45, 1, 1, 0, 0, "rs_add");
        cyc(1, 0, 46, 1, 1, 0, 1, "rs_pulse");
        chk("rst_fwd_zero", forwardOut, 23'h0);
        chk("rst_ovf_zero", {22'd0, queueOverflow}, 23'h0);
        idle(3, "rs_quiet");
        cyc(1, 8, 46, 16'hFFFF, 16'h0001, 0, 0, "slt");
        chk("slt_value", forwardOut, 23'h6E0001);
        cyc(1, 9, 47, 16'hFFFF, 16'h0001, 0, 0, "sltu");
        chk("sltu_value", forwardOut, 23'h6F0000);
        idle(2, "gap4");

        // Random traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            op = ($urandom_range(0, 2) == 0) ? 10 + $urandom_range(0, 1) : $urandom_range(0, 15);
            cyc($urandom_range(0, 4) != 0, op, $urandom_range(0, 63),
                $urandom_range(0, 65535), $urandom_range(0, 65535),
                $urandom_range(0, 39) == 0, 0, "rand");
        end
        idle(4, "rand_drain");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
